// File: rtl/fifo_read_arbiter.sv
// Read side of an asynchronous FIFO, shared by two requesters.
// Pops are arbitrated round-robin. Each pop is acknowledged one cycle after
// it is requested and delivers its word one cycle after that.
module fifo_read_arbiter #(
    parameter int addr_size = 3,
    parameter int data_size = 8
) (
    input  logic                 read_clock_i,
    input  logic                 read_reset_i,
    input  logic [addr_size:0]   write_to_read_pointer_i,
    input  logic [data_size-1:0] read_data_i,
    input  logic [1:0]           req_i,
    output logic [addr_size-1:0] read_address_o,
    output logic [addr_size:0]   read_pointer_o,
    output logic                 empty_o,
    output logic [addr_size:0]   level_o,
    output logic [1:0]           ack_o,
    output logic [1:0]           valid_o,
    output logic [data_size-1:0] data_o
);

    typedef enum logic {
        IDLE = 1'b0,
        POP  = 1'b1
    } state_t;

    localparam logic [addr_size:0] PTR_ONE = {{addr_size{1'b0}}, 1'b1};

    state_t               state;
    logic [addr_size:0]   rbin;
    logic [addr_size:0]   rbin_next;
    logic [1:0]           grant;
    logic [1:0]           next_grant;
    // Index of the requester served by the most recent pop.
    logic                 last_served;

    function automatic logic [addr_size:0] gray2bin(input logic [addr_size:0] g);
        logic [addr_size:0] b;
        b[addr_size] = g[addr_size];
        for (int i = addr_size - 1; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    assign rbin_next      = rbin + PTR_ONE;
    assign read_address_o = rbin[addr_size-1:0];
    // The registered Gray pointer is compared directly; both sides are Gray.
    assign empty_o        = (read_pointer_o == write_to_read_pointer_i);
    assign level_o        = gray2bin(write_to_read_pointer_i) - rbin;

    // Grant selection: a lone requester wins, a tie goes to whoever waited.
    always_comb begin
        next_grant = 2'b00;
        case (req_i)
            2'b01:   next_grant = 2'b01;
            2'b10:   next_grant = 2'b10;
            2'b11:   next_grant = last_served ? 2'b01 : 2'b10;
            default: next_grant = 2'b00;
        endcase
    end

    // Two-state pop sequencer with registered outputs and read pointer.
    always_ff @(posedge read_clock_i) begin
        if (read_reset_i) begin
            state          <= IDLE;
            rbin           <= '0;
            read_pointer_o <= '0;
            grant          <= 2'b00;
            last_served    <= 1'b1;
            ack_o          <= 2'b00;
            valid_o        <= 2'b00;
            data_o         <= '0;
        end else begin
            case (state)
                IDLE: begin
                    valid_o <= 2'b00;
                    ack_o   <= 2'b00;
                    if (!empty_o && (req_i != 2'b00)) begin
                        grant <= next_grant;
                        ack_o <= next_grant;
                        state <= POP;
                    end
                end
                POP: begin
                    // The grant completes regardless of req_i or pointer changes now.
                    ack_o          <= 2'b00;
                    valid_o        <= grant;
                    data_o         <= read_data_i;
                    rbin           <= rbin_next;
                    read_pointer_o <= rbin_next ^ (rbin_next >> 1);
                    last_served    <= grant[1];
                    state          <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
